// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller
//   Scans a 4x4 active-low keypad matrix, debounces presses and releases,
//   rejects multi-key (ghosting) scans and queues accepted key codes in a
//   first-word-fall-through FIFO that is popped over a valid/read handshake.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   rows       row drive, one-hot active-low (row 0 = 4'b1110)
//   cols       raw column inputs, active-low, asynchronous
//   rd_en      pop the FIFO head (ignored while empty)
//   key_valid  FIFO not empty
//   key_code   FIFO head {row[1:0], col[1:0]}
//   key_count  FIFO occupancy
//   overflow   sticky: a key was dropped because the FIFO was full
//   ovf_clr    clears overflow (a same-cycle drop wins)
//
// Optional feature
//   KEYPAD_REPEAT_EN: while a single key stays held, push its code again
//   every REPEAT_SCANS scans.
module keypad_scan_controller #(
  parameter int unsigned SCAN_CYCLES    = 8,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned REPEAT_SCANS   = 50
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [3:0]                    rows,
  input  logic [3:0]                    cols,
  input  logic                          rd_en,
  output logic                          key_valid,
  output logic [3:0]                    key_code,
  output logic [$clog2(FIFO_DEPTH):0]   key_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int unsigned SCW = $clog2(SCAN_CYCLES);
  localparam int unsigned DBW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  // ---------------- column synchronizer and row scan ----------------
  logic [3:0]     cols_s1, cols_s2;
  logic [SCW-1:0] scan_cnt;
  logic [1:0]     row_idx;
  logic [11:0]    cap;        // captures of rows 0..2; row 3 is taken live
  logic           row_end;
  logic           scan_done;

  assign row_end   = (scan_cnt == SCW'(SCAN_CYCLES - 1));
  assign scan_done = row_end && (row_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_s1  <= '1;
      cols_s2  <= '1;
      scan_cnt <= '0;
      row_idx  <= '0;
      rows     <= 4'b1110;
      cap      <= '1;
    end else begin
      cols_s1 <= cols;
      cols_s2 <= cols_s1;
      if (row_end) begin
        scan_cnt <= '0;
        row_idx  <= row_idx + 2'd1;
        rows     <= {rows[2:0], rows[3]};
        case (row_idx)
          2'd0:    cap[3:0]  <= cols_s2;
          2'd1:    cap[7:4]  <= cols_s2;
          2'd2:    cap[11:8] <= cols_s2;
          default: ;
        endcase
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // ---------------- per-scan classification ----------------
  // Row 3 is classified straight from the synchronizer so the verdict is
  // available on the same edge that would have captured it.
  logic [15:0] hits;
  logic [4:0]  hit_num;
  logic [3:0]  hit_code;
  logic        none, single;

  assign hits = ~{cols_s2, cap};

  always_comb begin
    hit_num  = '0;
    hit_code = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (hits[i]) begin
        hit_num  = hit_num + 5'd1;
        hit_code = 4'(i);
      end
    end
  end

  assign none   = (hit_num == 5'd0);
  assign single = (hit_num == 5'd1);

  // ---------------- press / release debounce FSM ----------------
  state_t         state;
  logic [DBW-1:0] db_cnt;
  logic [3:0]     cand;
  logic           push;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RPW = $clog2(REPEAT_SCANS + 1);
  logic [RPW-1:0] rpt_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      db_cnt <= '0;
      cand   <= '0;
      push   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt <= '0;
`endif
    end else begin
      push <= 1'b0;
      if (scan_done) begin
        unique case (state)
          IDLE: begin
            if (single) begin
              cand   <= hit_code;
              db_cnt <= DBW'(1);
              if (DEBOUNCE_SCANS == 1) begin
                push  <= 1'b1;
                state <= HELD;
              end else begin
                state <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (single) begin
              if (hit_code == cand) begin
                if (db_cnt + 1'b1 == DBW'(DEBOUNCE_SCANS)) begin
                  push  <= 1'b1;
                  state <= HELD;
                end else begin
                  db_cnt <= db_cnt + 1'b1;
                end
              end else begin
                cand   <= hit_code;
                db_cnt <= DBW'(1);
              end
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (none) begin
              db_cnt <= DBW'(1);
              state  <= (DEBOUNCE_SCANS == 1) ? IDLE : REL_DB;
            end
`ifdef KEYPAD_REPEAT_EN
            if (!single || hit_code != cand) begin
              rpt_cnt <= '0;
            end else if (rpt_cnt + 1'b1 == RPW'(REPEAT_SCANS)) begin
              push    <= 1'b1;
              rpt_cnt <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
`endif
          end
          REL_DB: begin
            if (none) begin
              if (db_cnt + 1'b1 == DBW'(DEBOUNCE_SCANS)) state <= IDLE;
              else db_cnt <= db_cnt + 1'b1;
            end else begin
              state <= HELD;
`ifdef KEYPAD_REPEAT_EN
              // a bounce back onto the held key still counts as a held scan
              rpt_cnt <= (single && hit_code == cand) ? RPW'(1) : '0;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---------------- key-code FIFO ----------------
  logic [3:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, do_pop, do_push, drop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = rd_en && key_valid;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= cand;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign key_valid = (count != '0);
  assign key_code  = key_valid ? mem[rd_ptr] : '0;
  assign key_count = count;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller (SCAN_CYCLES=4, DEBOUNCE_SCANS=2,
// FIFO_DEPTH=4). A keypad model pulls columns low for pressed keys in the
// driven row; a scan-level model (history window + queue) predicts outputs.
module tb_keypad_scan_controller;

  localparam int SC   = 4;
  localparam int DB   = 2;
  localparam int DEP  = 4;
  localparam int RPT  = 5;
  localparam int SCAN = 4 * SC;

  logic       clk, rst_n, rd_en, ovf_clr, key_valid, overflow;
  logic [3:0] rows, cols, key_code;
  logic [2:0] key_count;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;

  keypad_scan_controller #(
    .SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB), .FIFO_DEPTH(DEP), .REPEAT_SCANS(RPT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rows(rows), .cols(cols), .rd_en(rd_en),
    .key_valid(key_valid), .key_code(key_code), .key_count(key_count),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad matrix: a pressed key shorts its column to the driven row
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!rows[r]) cols = cols & ~pressed[r*4 +: 4];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scan-level model ----------------
  int          n;
  logic [15:0] smp;
  int          hist[$];
  bit          held, pend, m_ovf, m_pop, m_full, m_drop, same;
  int          pval, held_code, rpt, res, r, ones;
  logic [3:0]  q[$];
  logic [3:0]  exp_rows;

  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0; smp = '0; hist.delete(); held = 0; pend = 0; m_ovf = 0;
      q.delete(); rpt = 0;
    end else begin
      n++;
      m_full = (q.size() == DEP);
      m_pop  = rd_en && q.size() != 0;
      m_drop = 0;
      if (m_pop) void'(q.pop_front());
      if (pend) begin
        if (!m_full || m_pop) q.push_back(4'(pval));
        else m_drop = 1;
      end
      pend = 0;
      if (m_drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (n % SC == 0) begin
        r = (n / SC - 1) % 4;
        smp[r*4 +: 4] = pressed[r*4 +: 4];
        if (r == 3) begin
          ones = $countones(smp);
          res = (ones == 0) ? -1 : -2;
          if (ones == 1) for (int k = 0; k < 16; k++) if (smp[k]) res = k;
          hist.push_back(res);
          if (hist.size() > DB) void'(hist.pop_front());
          same = (hist.size() == DB);
          foreach (hist[i]) if (hist[i] != res) same = 0;
          if (!held) begin
            if (same && res >= 0) begin
              pend = 1; pval = res; held = 1; held_code = res; rpt = 0;
            end
          end else begin
            if (same && res == -1) held = 0;
`ifdef KEYPAD_REPEAT_EN
            if (res == held_code) begin
              rpt++;
              if (rpt == RPT) begin pend = 1; pval = held_code; rpt = 0; end
            end else rpt = 0;
`endif
          end
        end
      end
    end
    exp_rows = ~(4'b0001 << ((n / SC) % 4));
    #1;
    check("rows", rows, exp_rows);
    check("key_valid", key_valid, q.size() != 0);
    check("key_count", key_count, q.size());
    check("overflow", overflow, m_ovf);
    if (q.size() != 0) check("key_code", key_code, q[0]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic scans(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      while (n % SCAN != 0) @(negedge clk);
    end
  endtask

  task automatic set_keys(input logic [15:0] v);
    if (n % SCAN != 0) scans(1);
    pressed = v;
  endtask

  task automatic drain();
    for (int g = 0; g < 8 && key_valid; g++) begin
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
  endtask

  logic [3:0] row_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int wait_cnt;
  int keys [5] = '{1, 2, 4, 8, 15};

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; pressed = '0;
    repeat (3) @(negedge clk);
    check("rst_rows", rows, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_code", key_code, 4'h0);
    check("rst_count", key_count, 3'd0);
    check("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;

    // row rotation, one step per SC clocks, wrapping after 4 rows
    for (int k = 1; k <= SCAN; k++) begin
      @(negedge clk);
      check("row_step", rows, row_tbl[(k / SC) % 4]);
    end

    // key 9 (row 2, col 1): seen in scans ending at 32 and 48, pushed at 49
    set_keys(16'h0200);
    wait_cnt = 0;
    while (!key_valid && wait_cnt < 48) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("press_latency", wait_cnt, 33);
    check("press_code", key_code, 4'h9);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("pop_empty", key_valid, 1'b0);
    scans(10);
`ifndef KEYPAD_REPEAT_EN
    check("hold_no_push", key_count, 3'd0);
`endif
    set_keys('0);
    scans(3);
    drain();

    // bounce: key present every other scan never debounces
    for (int i = 0; i < 6; i++) begin
      set_keys((i % 2 == 0) ? 16'h0200 : 16'h0000);
      scans(1);
    end
    set_keys('0);
    scans(2);
    check("bounce_no_push", key_count, 3'd0);

    // short release does not retrigger, full release does
    set_keys(16'h0200); scans(3);
    check("press_a", key_count, 3'd1);
    set_keys('0);       scans(1);
    set_keys(16'h0200); scans(3);
    check("short_release", key_count, 3'd1);
    set_keys('0);       scans(2);
    set_keys(16'h0200); scans(3);
    check("full_release", key_count, 3'd2);
    check("second_code", key_code, 4'h9);
    set_keys('0); scans(3);
    drain();

    // ghosting: keys 0 and 5 together
    set_keys(16'h0021); scans(4);
    check("ghost_no_push", key_count, 3'd0);
    set_keys('0); scans(3);

    // overflow: five presses into a depth-4 queue
    foreach (keys[i]) begin
      set_keys(16'h0001 << keys[i]); scans(3);
      set_keys('0); scans(3);
    end
    check("ovf_count", key_count, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head", key_code, 4'h1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 1'b0);

    // push into full queue with same-cycle pop: both succeed
    set_keys(16'h0040); scans(2);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("full_pushpop_count", key_count, 3'd4);
    check("full_pushpop_head", key_code, 4'h2);
    check("full_pushpop_ovf", overflow, 1'b0);
    set_keys('0); scans(3);

    // drop coinciding with ovf_clr: set wins
    set_keys(16'h0080); scans(2);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("set_wins", overflow, 1'b1);
    set_keys('0); scans(3);

    // pop two, then reset in the middle of a press debounce
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    rd_en = 1'b0;
    check("two_queued", key_count, 3'd2);
    check("two_queued_head", key_code, 4'h8);
    set_keys(16'h0400); scans(1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    pressed = '0;
    #1;
    check("mid_rst_count", key_count, 3'd0);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_rows", rows, 4'b1110);
    check("mid_rst_ovf", overflow, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // scan restarts at row 0: press from release is pushed after 2 scans
    set_keys(16'h0200); scans(3);
    check("post_rst_count", key_count, 3'd1);
    check("post_rst_code", key_code, 4'h9);
    set_keys('0); scans(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
